// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control/execute unit in front of a 16x16 register file.
//   clk, reset (async, active-high)
//   instr_valid/instr/instr_ready : one-at-a-time instruction handshake
//   endereco_reg1/2, conteudo_reg1/2 : asynchronous operand reads
//   endereco_escrita/conteudo_escrita/enable : one-cycle write strobe
//   ativar_clear : one-cycle clear-all strobe
//   resultado : last written or displayed value
//   pronto/erro : completion pulse, erro flags an illegal opcode
module unidade_controle #(
   parameter int LARGURA = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [15:0]        instr,
   output logic               instr_ready,
   output logic [3:0]         endereco_reg1,
   output logic [3:0]         endereco_reg2,
   input  logic [LARGURA-1:0] conteudo_reg1,
   input  logic [LARGURA-1:0] conteudo_reg2,
   output logic [3:0]         endereco_escrita,
   output logic [LARGURA-1:0] conteudo_escrita,
   output logic               enable,
   output logic               ativar_clear,
   output logic [LARGURA-1:0] resultado,
   output logic               pronto,
   output logic               erro
);
   localparam int CW = $clog2(LARGURA);
   typedef enum logic [1:0] {OCIOSO, LEITURA, EXECUTA, ESCRITA} estado_t;
   estado_t estado;
   logic [15:0] instr_reg;
   logic [LARGURA-1:0] op_a, op_b, res;
   logic [CW-1:0] cnt;
   logic [3:0] op;
   logic escreve, limpa, ilegal, salta, imediato, subtrai, mul, mul_fim;
   assign op = instr_reg[15:12];
   assign escreve = (op != 4'd0) && (op <= 4'd5);
   assign limpa = op == 4'd6;
   assign ilegal = op[3];
   assign salta = (op == 4'd0) || limpa || ilegal;
   assign imediato = (op == 4'd2) || (op == 4'd4);
   assign subtrai = (op == 4'd3) || (op == 4'd4);
   assign mul = op == 4'd5;
   assign mul_fim = cnt == CW'(LARGURA - 1);
   assign endereco_reg1 = instr_reg[7:4];
   assign endereco_reg2 = instr_reg[3:0];
   assign endereco_escrita = instr_reg[11:8];
   assign conteudo_escrita = res;
   // Strobes are registered on the transition into ESCRITA, so they are high exactly while in ESCRITA.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
         instr_ready <= 1'b0;
         instr_reg <= '0;
         op_a <= '0;
         op_b <= '0;
         res <= '0;
         cnt <= '0;
         resultado <= '0;
         enable <= 1'b0;
         ativar_clear <= 1'b0;
         pronto <= 1'b0;
         erro <= 1'b0;
      end else begin
         enable <= 1'b0;
         ativar_clear <= 1'b0;
         pronto <= 1'b0;
         erro <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (instr_valid && instr_ready) begin
                  instr_reg <= instr;
                  instr_ready <= 1'b0;
                  estado <= LEITURA;
               end else begin
                  instr_ready <= 1'b1;
               end
            end
            LEITURA: begin
               op_a <= conteudo_reg1;
               op_b <= imediato ? {{(LARGURA-4){1'b0}}, instr_reg[3:0]} : conteudo_reg2;
               res <= '0;
               cnt <= '0;
               estado <= salta ? ESCRITA : EXECUTA;
               ativar_clear <= limpa;
               erro <= ilegal;
               pronto <= salta;
            end
            EXECUTA: begin
               if (mul) begin
                  // shift-add: one multiplier bit per cycle, fixed LARGURA cycles
                  res <= res + (op_b[0] ? op_a : '0);
                  op_a <= op_a << 1;
                  op_b <= op_b >> 1;
                  cnt <= cnt + 1'b1;
                  if (mul_fim) begin
                     estado <= ESCRITA;
                     enable <= 1'b1;
                     pronto <= 1'b1;
                  end
               end else begin
                  res <= subtrai ? op_a - op_b : (op == 4'd7) ? op_a : op_a + op_b;
                  estado <= ESCRITA;
                  enable <= escreve;
                  pronto <= 1'b1;
               end
            end
            ESCRITA: begin
               if (escreve || op == 4'd7) resultado <= res;
               instr_ready <= 1'b1;
               estado <= OCIOSO;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: directed bench with a register-file model around unidade_controle.
module tb_unidade_controle;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic instr_valid = 1'b0;
   logic [15:0] instr = '0;
   logic instr_ready, enable, ativar_clear, pronto, erro;
   logic [3:0] endereco_reg1, endereco_reg2, endereco_escrita;
   logic [15:0] conteudo_reg1, conteudo_reg2, conteudo_escrita, resultado;
   logic [15:0] rf [16];
   logic poke = 1'b0;
   logic [3:0] poke_a = '0;
   logic [15:0] poke_d = '0;
   int total = 0;
   int bad = 0;
   int en_c, pr_c, cl_c, er_c, en_n;
   logic [15:0] wdata;
   logic [3:0] waddr;
   always #5 clk = ~clk;
   unidade_controle dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
      .conteudo_reg1(conteudo_reg1), .conteudo_reg2(conteudo_reg2),
      .endereco_escrita(endereco_escrita), .conteudo_escrita(conteudo_escrita),
      .enable(enable), .ativar_clear(ativar_clear), .resultado(resultado), .pronto(pronto), .erro(erro)
   );
   assign conteudo_reg1 = rf[endereco_reg1];
   assign conteudo_reg2 = rf[endereco_reg2];
   always @(posedge clk) begin
      if (ativar_clear) for (int i = 0; i < 16; i++) rf[i] <= '0;
      else if (enable) rf[endereco_escrita] <= conteudo_escrita;
      else if (poke) rf[poke_a] <= poke_d;
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
      poke_a = a;
      poke_d = d;
      poke = 1'b1;
      step();
      poke = 1'b0;
   endtask
   // Issue one instruction and record, per cycle after the accept edge, where each strobe appears.
   task automatic run(input logic [15:0] ins);
      en_c = -1; pr_c = -1; cl_c = -1; er_c = -1; en_n = 0; wdata = '0; waddr = '0;
      for (int i = 0; i < 50 && instr_ready !== 1'b1; i++) step();
      if (instr_ready !== 1'b1) return;
      instr = ins;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (enable) begin
            en_n++;
            if (en_c < 0) en_c = c;
            wdata = conteudo_escrita;
            waddr = endereco_escrita;
         end
         if (ativar_clear && cl_c < 0) cl_c = c;
         if (erro && er_c < 0) er_c = c;
         if (pronto) begin
            pr_c = c;
            step();
            break;
         end
         step();
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", instr_ready); end
      total++; if ({enable, ativar_clear, pronto, erro} !== 4'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {enable, ativar_clear, pronto, erro}); end
      total++; if (resultado !== 16'h0) begin bad++; $display("FAIL reset_resultado: got %h want 0000", resultado); end
      #2 reset = 1'b0;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL release_ready: got %b want 0", instr_ready); end
      step();
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", instr_ready); end
      for (int i = 0; i < 16; i++) set_reg(4'(i), 16'h0);
   endtask
   task automatic test_addi();
      run(16'h2105);
      total++; if (en_c != 3) begin bad++; $display("FAIL addi_en_cycle: got %0d want 3", en_c); end
      total++; if (en_n != 1) begin bad++; $display("FAIL addi_en_count: got %0d want 1", en_n); end
      total++; if (pr_c != 3) begin bad++; $display("FAIL addi_pronto_cycle: got %0d want 3", pr_c); end
      total++; if (waddr !== 4'd1) begin bad++; $display("FAIL addi_addr: got %0d want 1", waddr); end
      total++; if (wdata !== 16'h0005) begin bad++; $display("FAIL addi_data: got %h want 0005", wdata); end
      total++; if (resultado !== 16'h0005) begin bad++; $display("FAIL addi_resultado: got %h want 0005", resultado); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL addi_ready_after: got %b want 1", instr_ready); end
   endtask
   task automatic test_add_sub();
      run(16'h2203);
      total++; if (wdata !== 16'h0003) begin bad++; $display("FAIL addi_r2: got %h want 0003", wdata); end
      run(16'h3321);
      total++; if (wdata !== 16'hFFFE) begin bad++; $display("FAIL sub_wrap: got %h want fffe", wdata); end
      total++; if (en_c != 3) begin bad++; $display("FAIL sub_en_cycle: got %0d want 3", en_c); end
      run(16'h1411);
      total++; if (wdata !== 16'h000A) begin bad++; $display("FAIL add_data: got %h want 000a", wdata); end
      total++; if (waddr !== 4'd4) begin bad++; $display("FAIL add_addr: got %0d want 4", waddr); end
      run(16'h4617);
      total++; if (resultado !== 16'hFFFE) begin bad++; $display("FAIL subi_wrap: got %h want fffe", resultado); end
   endtask
   task automatic test_mul();
      set_reg(4'd1, 16'h0100);
      set_reg(4'd2, 16'h0101);
      run(16'h5512);
      total++; if (en_c != 18) begin bad++; $display("FAIL mul_en_cycle: got %0d want 18", en_c); end
      total++; if (en_n != 1) begin bad++; $display("FAIL mul_en_count: got %0d want 1", en_n); end
      total++; if (pr_c != 18) begin bad++; $display("FAIL mul_pronto_cycle: got %0d want 18", pr_c); end
      total++; if (wdata !== 16'h0100) begin bad++; $display("FAIL mul_trunc: got %h want 0100", wdata); end
      total++; if (waddr !== 4'd5) begin bad++; $display("FAIL mul_addr: got %0d want 5", waddr); end
      set_reg(4'd7, 16'hFFFF);
      set_reg(4'd8, 16'hFFFF);
      run(16'h5978);
      total++; if (resultado !== 16'h0001) begin bad++; $display("FAIL mul_ffff: got %h want 0001", resultado); end
      run(16'h7050);
      total++; if (resultado !== 16'h0100) begin bad++; $display("FAIL display_r5: got %h want 0100", resultado); end
      total++; if (en_n != 0 || pr_c != 3) begin bad++; $display("FAIL display_timing: got en=%0d pronto=%0d want en=0 pronto=3", en_n, pr_c); end
   endtask
   task automatic test_clear();
      run(16'h6000);
      total++; if (cl_c != 2) begin bad++; $display("FAIL clear_cycle: got %0d want 2", cl_c); end
      total++; if (pr_c != 2) begin bad++; $display("FAIL clear_pronto: got %0d want 2", pr_c); end
      total++; if (en_n != 0 || er_c != -1) begin bad++; $display("FAIL clear_no_write: got en=%0d erro=%0d want 0/-1", en_n, er_c); end
      run(16'h7010);
      total++; if (resultado !== 16'h0000) begin bad++; $display("FAIL display_after_clear: got %h want 0000", resultado); end
   endtask
   task automatic test_illegal();
      run(16'h2109);
      run(16'hF123);
      total++; if (pr_c != 2 || er_c != 2) begin bad++; $display("FAIL illegal_pulse: got pronto=%0d erro=%0d want 2/2", pr_c, er_c); end
      total++; if (en_n != 0 || cl_c != -1) begin bad++; $display("FAIL illegal_no_write: got en=%0d clr=%0d want 0/-1", en_n, cl_c); end
      total++; if (resultado !== 16'h0009) begin bad++; $display("FAIL illegal_resultado: got %h want 0009", resultado); end
      run(16'h0000);
      total++; if (pr_c != 2 || er_c != -1 || en_n != 0) begin bad++; $display("FAIL nop: got pronto=%0d erro=%0d en=%0d want 2/-1/0", pr_c, er_c, en_n); end
      total++; if (resultado !== 16'h0009) begin bad++; $display("FAIL nop_resultado: got %h want 0009", resultado); end
   endtask
   task automatic test_back_to_back();
      logic [8:0] rdy = '0;
      logic [8:0] prn = '0;
      for (int i = 0; i < 50 && instr_ready !== 1'b1; i++) step();
      instr = 16'h2111;
      instr_valid = 1'b1;
      step();
      for (int c = 1; c <= 8; c++) begin
         rdy[c] = instr_ready;
         prn[c] = pronto;
         if (c == 7) instr_valid = 1'b0;
         if (c < 8) step();
      end
      total++; if (rdy !== 9'b1_0001_0000) begin bad++; $display("FAIL b2b_ready: got %b want 100010000", rdy); end
      total++; if (prn !== 9'b0_1000_1000) begin bad++; $display("FAIL b2b_pronto: got %b want 010001000", prn); end
      total++; if (resultado !== 16'h000B) begin bad++; $display("FAIL b2b_resultado: got %h want 000b", resultado); end
      total++; if (rf[1] !== 16'h000B) begin bad++; $display("FAIL b2b_rf1: got %h want 000b", rf[1]); end
   endtask
   task automatic test_reset_mid_mul();
      int n = 0;
      set_reg(4'd1, 16'h0003);
      set_reg(4'd2, 16'h0004);
      for (int i = 0; i < 50 && instr_ready !== 1'b1; i++) step();
      instr = 16'h5A12;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (enable || pronto) n++;
         step();
      end
      reset = 1'b1;
      #1;
      total++; if ({enable, pronto, instr_ready} !== 3'b0) begin bad++; $display("FAIL midmul_reset_outs: got %b want 000", {enable, pronto, instr_ready}); end
      total++; if (resultado !== 16'h0000) begin bad++; $display("FAIL midmul_resultado: got %h want 0000", resultado); end
      repeat (2) step();
      #2 reset = 1'b0;
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL midmul_release_ready: got %b want 0", instr_ready); end
      step();
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL midmul_ready_after: got %b want 1", instr_ready); end
      for (int c = 0; c < 30; c++) begin
         if (enable || pronto) n++;
         step();
      end
      total++; if (n != 0 || rf[10] !== 16'h0000) begin bad++; $display("FAIL midmul_no_write: got strobes=%0d r10=%h want 0/0000", n, rf[10]); end
      run(16'h2A15);
      total++; if (en_c != 3 || wdata !== 16'h0008) begin bad++; $display("FAIL after_reset_addi: got cyc=%0d data=%h want 3/0008", en_c, wdata); end
   endtask
   initial begin
      test_reset();
      test_addi();
      test_add_sub();
      test_mul();
      test_clear();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
